tpu_dma_mc_reader: RTL and testbench

TPU_DMA_MC_READER -- requirements
Module: tpu_dma_mc_reader

---
 rtl/tpu_dma_mc_reader.sv | 276 +++++++++++++++++++++++++++
 tb/tb_tpu_dma_mc_reader.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_dma_mc_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tpu_dma_mc_reader                                         |
// | Brief    : Multi-channel AXI4 read DMA that fills a word-addressed   |
// |            buffer. One burst is in flight at a time and channels     |
// |            are arbitrated round-robin per burst.                     |
// | Options  : define TPU_DMA_4K_SPLIT_EN to keep every burst inside a   |
// |            4096-byte address window.                                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tpu_dma_mc_reader #(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_CH        = 2,
   parameter int MAX_BURST_LEN = 16,
   parameter int LEN_WIDTH     = 16,
   parameter int BUF_AW        = 16
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [NUM_CH-1:0]                         ch_start,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]              ch_src_addr,
   input  logic [NUM_CH*BUF_AW-1:0]                  ch_dst_addr,
   input  logic [NUM_CH*LEN_WIDTH-1:0]               ch_len,
   output logic [NUM_CH-1:0]                         ch_busy,
   output logic [NUM_CH-1:0]                         ch_done,
   output logic [NUM_CH-1:0]                         ch_error,
   output logic                                      m_axi_arvalid,
   input  logic                                      m_axi_arready,
   output logic [ADDR_WIDTH-1:0]                     m_axi_araddr,
   output logic [7:0]                                m_axi_arlen,
   output logic [2:0]                                m_axi_arsize,
   output logic [1:0]                                m_axi_arburst,
   input  logic                                      m_axi_rvalid,
   output logic                                      m_axi_rready,
   input  logic [DATA_WIDTH-1:0]                     m_axi_rdata,
   input  logic [1:0]                                m_axi_rresp,
   input  logic                                      m_axi_rlast,
   output logic                                      buf_wr_en,
   output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] buf_wr_ch,
   output logic [BUF_AW-1:0]                         buf_wr_addr,
   output logic [DATA_WIDTH-1:0]                     buf_wr_data
);

   localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int WORD_BYTES = DATA_WIDTH / 8;
   localparam int SIZE_LOG   = $clog2(WORD_BYTES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARB  = 2'd1;
   localparam logic [1:0] S_ADDR = 2'd2;
   localparam logic [1:0] S_DATA = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [CHW-1:0]        cur_q, cur_d;
   logic [CHW-1:0]        ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [7:0]            arlen_q, arlen_d;
   logic                  arvalid_q, arvalid_d;
   logic                  abort_q, abort_d;
   logic [NUM_CH-1:0]     busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [ADDR_WIDTH-1:0] src_q [NUM_CH];
   logic [ADDR_WIDTH-1:0] src_d [NUM_CH];
   logic [BUF_AW-1:0]     dst_q [NUM_CH];
   logic [BUF_AW-1:0]     dst_d [NUM_CH];
   logic [LEN_WIDTH-1:0]  rem_q [NUM_CH];   // words not yet requested
   logic [LEN_WIDTH-1:0]  rem_d [NUM_CH];
   logic                  wr_en_q, wr_en_d;
   logic [CHW-1:0]        wr_ch_q, wr_ch_d;
   logic [BUF_AW-1:0]     wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  fin_q, fin_d;     // completion lands one cycle after the last write
   logic [CHW-1:0]        fin_ch_q, fin_ch_d;

   logic [NUM_CH-1:0]     elig;
   logic                  grant_vld;
   logic [CHW-1:0]        grant;
   logic [31:0]           beats;

   // A channel competes for the bus only while it still has words to request
   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_elig
         assign elig[g] = busy_q[g] && (rem_q[g] != '0);
      end
   endgenerate

   // Round-robin pick starting at the channel after the last one served
   always_comb begin
      int idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant     = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!grant_vld && elig[idx]) begin
            grant_vld = 1'b1;
            grant     = CHW'(idx);
         end
      end
   end

`ifdef TPU_DMA_4K_SPLIT_EN
   logic [31:0] to4k;
`endif

   // Beat count for the burst the granted channel would issue now
   always_comb begin
      beats = 32'(rem_q[grant]);
      if (beats > 32'(MAX_BURST_LEN)) beats = 32'(MAX_BURST_LEN);
`ifdef TPU_DMA_4K_SPLIT_EN
      to4k = (32'd4096 - {20'd0, src_q[grant][11:0]}) >> SIZE_LOG;
      if (to4k == 32'd0) to4k = 32'd1;
      if (beats > to4k) beats = to4k;
`endif
   end

   // Channel bookkeeping, burst sequencing and buffer-write staging
   always_comb begin
      logic [LEN_WIDTH-1:0] len_i;
      len_i     = '0;
      state_d   = state_q;
      cur_d     = cur_q;
      ptr_d     = ptr_q;
      araddr_d  = araddr_q;
      arlen_d   = arlen_q;
      arvalid_d = arvalid_q;
      abort_d   = abort_q;
      busy_d    = busy_q;
      done_d    = '0;
      err_d     = err_q;
      src_d     = src_q;
      dst_d     = dst_q;
      rem_d     = rem_q;
      wr_en_d   = 1'b0;
      wr_ch_d   = wr_ch_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      fin_d     = 1'b0;
      fin_ch_d  = fin_ch_q;

      if (fin_q) begin
         busy_d[fin_ch_q] = 1'b0;
         done_d[fin_ch_q] = 1'b1;
      end

      // Idle channels accept a start; malformed lengths finish immediately with error
      for (int i = 0; i < NUM_CH; i++) begin
         len_i = ch_len[i*LEN_WIDTH +: LEN_WIDTH];
         if (ch_start[i] && !busy_q[i]) begin
            if ((len_i == '0) || (len_i[SIZE_LOG-1:0] != '0)) begin
               err_d[i]  = 1'b1;
               done_d[i] = 1'b1;
            end else begin
               busy_d[i] = 1'b1;
               err_d[i]  = 1'b0;
               src_d[i]  = ch_src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
               dst_d[i]  = ch_dst_addr[i*BUF_AW +: BUF_AW];
               rem_d[i]  = len_i >> SIZE_LOG;
            end
         end
      end

      case (state_q)
         S_IDLE: begin
            if (|elig) state_d = S_ARB;
         end
         S_ARB: begin
            if (grant_vld) begin
               cur_d        = grant;
               ptr_d        = (grant == CHW'(NUM_CH - 1)) ? '0 : grant + CHW'(1);
               araddr_d     = src_q[grant];
               arlen_d      = 8'(beats - 32'd1);
               arvalid_d    = 1'b1;
               abort_d      = 1'b0;
               src_d[grant] = src_q[grant] + ADDR_WIDTH'(beats * 32'(WORD_BYTES));
               rem_d[grant] = rem_q[grant] - LEN_WIDTH'(beats);
               state_d      = S_ADDR;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ADDR: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               state_d   = S_DATA;
            end
         end
         default: begin
            if (m_axi_rvalid) begin
               if (m_axi_rresp == 2'b00) begin
                  wr_en_d      = 1'b1;
                  wr_ch_d      = cur_q;
                  wr_addr_d    = dst_q[cur_q];
                  wr_data_d    = m_axi_rdata;
                  dst_d[cur_q] = dst_q[cur_q] + BUF_AW'(1);
               end else begin
                  abort_d      = 1'b1;
                  err_d[cur_q] = 1'b1;
               end
               if (m_axi_rlast) begin
                  if ((rem_q[cur_q] == '0) || abort_q || (m_axi_rresp != 2'b00)) begin
                     fin_d        = 1'b1;
                     fin_ch_d     = cur_q;
                     rem_d[cur_q] = '0;
                  end
                  state_d = (|busy_d) ? S_ARB : S_IDLE;
               end
            end
         end
      endcase
   end

   // State registers; reset abandons any burst in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cur_q     <= '0;
         ptr_q     <= '0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arvalid_q <= 1'b0;
         abort_q   <= 1'b0;
         busy_q    <= '0;
         done_q    <= '0;
         err_q     <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            src_q[i] <= '0;
            dst_q[i] <= '0;
            rem_q[i] <= '0;
         end
         wr_en_q   <= 1'b0;
         wr_ch_q   <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         fin_q     <= 1'b0;
         fin_ch_q  <= '0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         ptr_q     <= ptr_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
         arvalid_q <= arvalid_d;
         abort_q   <= abort_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         rem_q     <= rem_d;
         wr_en_q   <= wr_en_d;
         wr_ch_q   <= wr_ch_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         fin_q     <= fin_d;
         fin_ch_q  <= fin_ch_d;
      end
   end

   assign ch_busy       = busy_q;
   assign ch_done       = done_q;
   assign ch_error      = err_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arlen   = arlen_q;
   assign m_axi_arsize  = 3'(SIZE_LOG);
   assign m_axi_arburst = 2'b01;
   assign m_axi_rready  = (state_q == S_DATA);
   assign buf_wr_en     = wr_en_q;
   assign buf_wr_ch     = wr_ch_q;
   assign buf_wr_addr   = wr_addr_q;
   assign buf_wr_data   = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_tpu_dma_mc_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_tpu_dma_mc_reader                                      |
// | Brief    : Directed bench for tpu_dma_mc_reader with a simple AXI    |
// |            read slave returning addr ^ PAT as data.                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_tpu_dma_mc_reader;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int NCH = 2;
   localparam int LW  = 16;
   localparam int BAW = 16;
   localparam logic [31:0] PAT = 32'hC0DE_0000;

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    ch_start;
   logic [NCH*AW-1:0] ch_src_addr;
   logic [NCH*BAW-1:0] ch_dst_addr;
   logic [NCH*LW-1:0] ch_len;
   logic [NCH-1:0]    ch_busy, ch_done, ch_error;
   logic              m_axi_arvalid, m_axi_arready;
   logic [AW-1:0]     m_axi_araddr;
   logic [7:0]        m_axi_arlen;
   logic [2:0]        m_axi_arsize;
   logic [1:0]        m_axi_arburst;
   logic              m_axi_rvalid, m_axi_rready, m_axi_rlast;
   logic [DW-1:0]     m_axi_rdata;
   logic [1:0]        m_axi_rresp;
   logic              buf_wr_en;
   logic [0:0]        buf_wr_ch;
   logic [BAW-1:0]    buf_wr_addr;
   logic [DW-1:0]     buf_wr_data;

   tpu_dma_mc_reader #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NCH),
      .MAX_BURST_LEN(16), .LEN_WIDTH(LW), .BUF_AW(BAW)
   ) dut (
      .clk(clk), .rst(rst), .ch_start(ch_start), .ch_src_addr(ch_src_addr),
      .ch_dst_addr(ch_dst_addr), .ch_len(ch_len), .ch_busy(ch_busy),
      .ch_done(ch_done), .ch_error(ch_error),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
      .buf_wr_en(buf_wr_en), .buf_wr_ch(buf_wr_ch),
      .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int err_beat = -1;
   logic [31:0]  ar_addr_log[$];
   logic [7:0]   ar_len_log[$];
   logic [0:0]   wr_ch_log[$];
   logic [15:0]  wr_addr_log[$];
   logic [31:0]  wr_data_log[$];
   int           done_cnt[NCH];
   logic         busy_at_done[NCH];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Record handshakes, buffer writes and completions
   always @(negedge clk) begin
      if (m_axi_arvalid && m_axi_arready) begin
         ar_addr_log.push_back(m_axi_araddr);
         ar_len_log.push_back(m_axi_arlen);
      end
      if (buf_wr_en) begin
         wr_ch_log.push_back(buf_wr_ch);
         wr_addr_log.push_back(buf_wr_addr);
         wr_data_log.push_back(buf_wr_data);
      end
      for (int i = 0; i < NCH; i++)
         if (ch_done[i]) begin
            done_cnt[i]++;
            busy_at_done[i] = ch_busy[i];
         end
   end

   // AXI read slave: toggling arready, back-to-back data, optional error beat
   initial begin : axi_slave
      logic hs_ar, hs_r, active, tog;
      logic [31:0] a_addr, s_addr;
      logic [7:0]  a_len;
      int s_left, s_beat;
      active = 1'b0; tog = 1'b0; s_addr = '0; s_left = 0; s_beat = 0;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
      m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
      forever begin
         @(negedge clk);
         hs_ar  = m_axi_arvalid && m_axi_arready;
         hs_r   = m_axi_rvalid && m_axi_rready;
         a_addr = m_axi_araddr;
         a_len  = m_axi_arlen;
         @(posedge clk);
         #1;
         if (rst) begin
            active = 1'b0;
         end else if (hs_ar) begin
            active = 1'b1; s_addr = a_addr; s_left = int'(a_len) + 1; s_beat = 0;
         end else if (hs_r && active) begin
            s_addr = s_addr + 32'd4; s_left--; s_beat++;
            if (s_left == 0) active = 1'b0;
         end
         tog = ~tog;
         m_axi_arready = !active && tog;
         m_axi_rvalid  = active;
         m_axi_rdata   = s_addr ^ PAT;
         m_axi_rresp   = (active && s_beat == err_beat) ? 2'b10 : 2'b00;
         m_axi_rlast   = active && (s_left == 1);
      end
   end

   task automatic clear_logs();
      @(posedge clk);
      ar_addr_log.delete(); ar_len_log.delete();
      wr_ch_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
      for (int i = 0; i < NCH; i++) begin
         done_cnt[i] = 0;
         busy_at_done[i] = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic set_ch(input int ch, input logic [31:0] src, input logic [15:0] dst,
                         input logic [15:0] len);
      ch_src_addr[ch*AW +: AW]   = src;
      ch_dst_addr[ch*BAW +: BAW] = dst;
      ch_len[ch*LW +: LW]        = len;
   endtask

   task automatic pulse(input logic [NCH-1:0] m);
      ch_start = m;
      @(negedge clk);
      ch_start = '0;
   endtask

   task automatic wait_done(input int ch, input int target, input string tag);
      int n;
      n = 0;
      while (done_cnt[ch] < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk(tag, 64'(done_cnt[ch]), 64'(target));
   endtask

   // Directed sequence
   initial begin : stim
      int n, b, c, w;
      logic [31:0] exp_ar[4];
      rst = 1'b1; ch_start = '0; ch_src_addr = '0; ch_dst_addr = '0; ch_len = '0;
      for (int i = 0; i < NCH; i++) begin done_cnt[i] = 0; busy_at_done[i] = 1'b1; end
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(ch_busy), 64'h0);
      chk("rst_done", 64'(ch_done), 64'h0);
      chk("rst_err", 64'(ch_error), 64'h0);
      chk("rst_arvalid", 64'(m_axi_arvalid), 64'h0);
      chk("rst_rready", 64'(m_axi_rready), 64'h0);
      chk("rst_wr_en", 64'(buf_wr_en), 64'h0);
      chk("rst_arsize", 64'(m_axi_arsize), 64'h2);
      chk("rst_arburst", 64'(m_axi_arburst), 64'h1);
      rst = 1'b0;

      // Single-beat transfer
      clear_logs();
      set_ch(0, 32'h1000, 16'h0010, 16'd4);
      pulse(2'b01);
      chk("t1_busy_rise", 64'(ch_busy[0]), 64'h1);
      wait_done(0, 1, "t1_done");
      chk("t1_ar_cnt", 64'(ar_addr_log.size()), 64'd1);
      if (ar_addr_log.size() > 0) begin
         chk("t1_araddr", 64'(ar_addr_log[0]), 64'h1000);
         chk("t1_arlen", 64'(ar_len_log[0]), 64'h0);
      end
      chk("t1_wr_cnt", 64'(wr_addr_log.size()), 64'd1);
      if (wr_addr_log.size() > 0) begin
         chk("t1_wr_addr", 64'(wr_addr_log[0]), 64'h10);
         chk("t1_wr_data", 64'(wr_data_log[0]), 64'(32'h1000 ^ PAT));
      end
      chk("t1_err", 64'(ch_error[0]), 64'h0);
      chk("t1_busy_fall", 64'(busy_at_done[0]), 64'h0);

      // Two full bursts, plus a start while busy that must be ignored
      clear_logs();
      set_ch(0, 32'h2000, 16'h0100, 16'd128);
      pulse(2'b01);
      repeat (3) @(negedge clk);
      set_ch(0, 32'hF000, 16'h0000, 16'd4);
      pulse(2'b01);
      wait_done(0, 1, "t2_done");
      repeat (10) @(negedge clk);
      chk("t2_done_once", 64'(done_cnt[0]), 64'd1);
      chk("t2_ar_cnt", 64'(ar_addr_log.size()), 64'd2);
      if (ar_addr_log.size() == 2) begin
         chk("t2_araddr0", 64'(ar_addr_log[0]), 64'h2000);
         chk("t2_araddr1", 64'(ar_addr_log[1]), 64'h2040);
         chk("t2_arlen1", 64'(ar_len_log[1]), 64'd15);
      end
      chk("t2_wr_cnt", 64'(wr_addr_log.size()), 64'd32);
      n = 0;
      for (int k = 0; k < wr_addr_log.size(); k++)
         if (wr_addr_log[k] !== 16'(32'h100 + k) || wr_ch_log[k] !== 1'b0 ||
             wr_data_log[k] !== ((32'h2000 + 32'(4 * k)) ^ PAT)) n++;
      chk("t2_wr_seq", 64'(n), 64'd0);

      // Transfer straddling the 4 KB boundary
      clear_logs();
      set_ch(0, 32'h0FF8, 16'h0000, 16'd32);
      pulse(2'b01);
      wait_done(0, 1, "t3_done");
`ifdef TPU_DMA_4K_SPLIT_EN
      chk("t3_ar_cnt", 64'(ar_addr_log.size()), 64'd2);
      if (ar_addr_log.size() == 2) begin
         chk("t3_ar0", {ar_addr_log[0], 24'd0, ar_len_log[0]}, {32'h0FF8, 32'd1});
         chk("t3_ar1", {ar_addr_log[1], 24'd0, ar_len_log[1]}, {32'h1000, 32'd5});
      end
`else
      chk("t3_ar_cnt", 64'(ar_addr_log.size()), 64'd1);
      if (ar_addr_log.size() == 1)
         chk("t3_ar0", {ar_addr_log[0], 24'd0, ar_len_log[0]}, {32'h0FF8, 32'd7});
`endif
      chk("t3_wr_cnt", 64'(wr_addr_log.size()), 64'd8);

      // Two channels interleave per burst; ch1 is next in round-robin order
      clear_logs();
      set_ch(0, 32'h4000, 16'h0200, 16'd128);
      set_ch(1, 32'h8000, 16'h0300, 16'd128);
      pulse(2'b11);
      wait_done(0, 1, "t4_done0");
      wait_done(1, 1, "t4_done1");
      exp_ar[0] = 32'h8000; exp_ar[1] = 32'h4000; exp_ar[2] = 32'h8040; exp_ar[3] = 32'h4040;
      chk("t4_ar_cnt", 64'(ar_addr_log.size()), 64'd4);
      n = 0;
      for (int k = 0; k < ar_addr_log.size() && k < 4; k++)
         if (ar_addr_log[k] !== exp_ar[k] || ar_len_log[k] !== 8'd15) n++;
      chk("t4_ar_order", 64'(n), 64'd0);
      chk("t4_wr_cnt", 64'(wr_addr_log.size()), 64'd64);
      n = 0;
      for (int k = 0; k < wr_addr_log.size(); k++) begin
         b = k / 16;
         c = (b % 2 == 0) ? 1 : 0;
         w = (b / 2) * 16 + (k % 16);
         if (wr_ch_log[k] !== 1'(c) ||
             wr_addr_log[k] !== 16'((c == 1 ? 32'h300 : 32'h200) + w) ||
             wr_data_log[k] !== (((c == 1 ? 32'h8000 : 32'h4000) + 32'(4 * w)) ^ PAT)) n++;
      end
      chk("t4_wr_seq", 64'(n), 64'd0);

      // Start on ch1 in the very cycle ch0 takes its rlast
      clear_logs();
      set_ch(0, 32'h5000, 16'h0020, 16'd4);
      set_ch(1, 32'h6000, 16'h0040, 16'd8);
      pulse(2'b01);
      n = 0;
      while (!(m_axi_rvalid && m_axi_rready && m_axi_rlast) && n < 200) begin
         @(negedge clk);
         n++;
      end
      pulse(2'b10);
      wait_done(0, 1, "t5_done0");
      wait_done(1, 1, "t5_done1");
      chk("t5_wr_cnt", 64'(wr_addr_log.size()), 64'd3);
      if (wr_addr_log.size() == 3)
         chk("t5_wr_ch1", {wr_ch_log[2], 15'd0, wr_addr_log[2], wr_data_log[2]},
             {1'b1, 15'd0, 16'h0041, 32'h6004 ^ PAT});

      // Slave error on beat index 3 aborts the channel after draining
      clear_logs();
      err_beat = 3;
      set_ch(0, 32'h9000, 16'h0400, 16'd128);
      pulse(2'b01);
      wait_done(0, 1, "t6_done");
      err_beat = -1;
      repeat (10) @(negedge clk);
      chk("t6_ar_cnt", 64'(ar_addr_log.size()), 64'd1);
      chk("t6_wr_cnt", 64'(wr_addr_log.size()), 64'd15);
      n = 0;
      for (int k = 0; k < wr_addr_log.size(); k++) begin
         w = (k < 3) ? k : k + 1;
         if (wr_addr_log[k] !== 16'(32'h400 + k) ||
             wr_data_log[k] !== ((32'h9000 + 32'(4 * w)) ^ PAT)) n++;
      end
      chk("t6_wr_seq", 64'(n), 64'd0);
      chk("t6_err", 64'(ch_error[0]), 64'h1);
      chk("t6_busy", 64'(ch_busy[0]), 64'h0);

      // Length not a word multiple: immediate error completion, no traffic
      clear_logs();
      set_ch(0, 32'h3000, 16'h0000, 16'd6);
      pulse(2'b01);
      chk("t7_done", 64'(ch_done[0]), 64'h1);
      chk("t7_busy", 64'(ch_busy[0]), 64'h0);
      chk("t7_err", 64'(ch_error[0]), 64'h1);
      @(negedge clk);
      chk("t7_done_1cyc", 64'(ch_done[0]), 64'h0);
      repeat (5) @(negedge clk);
      chk("t7_no_ar", 64'(ar_addr_log.size()), 64'd0);

      // Next accepted start clears the sticky error
      clear_logs();
      set_ch(0, 32'h1000, 16'h0010, 16'd4);
      pulse(2'b01);
      chk("t8_err_clr", 64'(ch_error[0]), 64'h0);
      wait_done(0, 1, "t8_done");

      // Asynchronous reset in the middle of a burst, then a clean restart
      clear_logs();
      set_ch(0, 32'hA000, 16'h0600, 16'd128);
      pulse(2'b01);
      n = 0;
      while (wr_addr_log.size() < 5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      #2 rst = 1'b1;
      #1;
      chk("t9_busy", 64'(ch_busy), 64'h0);
      chk("t9_arvalid", 64'(m_axi_arvalid), 64'h0);
      chk("t9_rready", 64'(m_axi_rready), 64'h0);
      chk("t9_wr", {31'd0, buf_wr_en, 16'd0, buf_wr_addr}, 64'h0);
      chk("t9_arburst", 64'(m_axi_arburst), 64'h1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_logs();
      set_ch(1, 32'hB000, 16'h0500, 16'd8);
      pulse(2'b10);
      wait_done(1, 1, "t9_done");
      chk("t9_ar", {32'(ar_addr_log.size()), ar_addr_log.size() > 0 ? ar_addr_log[0] : 32'h0},
          {32'd1, 32'hB000});
      chk("t9_wr_cnt", 64'(wr_addr_log.size()), 64'd2);
      if (wr_addr_log.size() == 2)
         chk("t9_wr1", {wr_ch_log[1], 15'd0, wr_addr_log[1], wr_data_log[1]},
             {1'b1, 15'd0, 16'h0501, 32'hB004 ^ PAT});
      chk("t9_err", 64'(ch_error), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
